framed_encoder_tx: RTL and testbench

Transmit-side companion of the line decoder. It accepts bytes on a valid/ready handshake and prefixes each burst with a fixed preamble. It serializes the bits LSB first and passes them through the recursive line encoder y[n] = x[n] ^ y[n-1] ^ y[n-2] ^ y[n-3] ^ y[n-6]. One encoded bit leaves on `out` every clock. The decoder at the far end (taps in, D1, D2, D3, D6; history cleared at reset) recovers x[n] exactly from the first bit after both ends leave reset.

---
 rtl/framed_encoder_tx.sv | 132 +++++++++++++
 tb/tb_framed_encoder_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/framed_encoder_tx.sv
// -----------------------------------------------------------------------------
// framed_encoder_tx
//
// Purpose:
//   Transmit side of a framed serial link. Bytes arrive on a valid/ready
//   handshake. Each burst begins with a fixed preamble, and then the bytes are
//   serialized LSB first. Every bit, including the idle zeros between bursts,
//   goes through the recursive line encoder
//       y[n] = x[n] ^ y[n-1] ^ y[n-2] ^ y[n-3] ^ y[n-6]
//   and one encoded bit leaves on `out` on every clock.
//
// Parameters:
//   PRE_LEN      preamble length in bits (1..8)
//   PRE_PATTERN  preamble bits, sent LSB first; bits [PRE_LEN-1:0] are used
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-low; clears all state immediately
//   data_in     in   byte to send
//   data_valid  in   data_in is valid
//   data_ready  out  block accepts data_in this cycle (decoded from state only)
//   out         out  encoded serial bit, registered
//   busy        out  high while a preamble or data bits are being sent
// -----------------------------------------------------------------------------
module framed_encoder_tx #(
    parameter int unsigned PRE_LEN     = 8,
    parameter logic [7:0]  PRE_PATTERN = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       out,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [2:0] PRE_LAST = 3'(PRE_LEN - 1);

    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shreg_q;
    logic [6:1] h_q;        // encoder history, h_q[k] = y[n-k]
    logic       busy_q;

    logic       x_d;        // unencoded bit for the current cycle
    logic       h1_d;       // next encoded bit
    logic       xfer;

    // Ready is a pure decode of the state: a byte can be accepted in IDLE,
    // or in DATA on the last bit so that the next byte follows with no gap.
    assign data_ready = (state_q == ST_IDLE) ||
                        ((state_q == ST_DATA) && (bit_cnt_q == 3'd7));
    assign xfer       = data_valid && data_ready;

    always_comb begin
        x_d = 1'b0;
        case (state_q)
            ST_PRE:  x_d = PRE_PATTERN[bit_cnt_q];
            ST_DATA: x_d = shreg_q[bit_cnt_q];
            default: x_d = 1'b0;
        endcase
    end

    assign h1_d = x_d ^ h_q[1] ^ h_q[2] ^ h_q[3] ^ h_q[6];

    assign out  = h_q[1];
    assign busy = busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shreg_q   <= 8'd0;
            h_q       <= 6'd0;
            busy_q    <= 1'b0;
        end else begin
            // The encoder runs in every state, so the far-end decoder stays
            // in lock across idle periods (idle zeros are encoded too).
            h_q <= {h_q[5:1], h1_d};

            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        shreg_q   <= data_in;
                        bit_cnt_q <= 3'd0;
                        state_q   <= ST_PRE;
                        busy_q    <= 1'b1;
                    end
                end

                ST_PRE: begin
                    if (bit_cnt_q == PRE_LAST) begin
                        bit_cnt_q <= 3'd0;
                        state_q   <= ST_DATA;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                end

                ST_DATA: begin
                    if (bit_cnt_q == 3'd7) begin
                        if (xfer) begin
                            // Back-to-back byte: no preamble, no gap.
                            shreg_q   <= data_in;
                            bit_cnt_q <= 3'd0;
                        end else begin
                            bit_cnt_q <= 3'd0;
                            state_q   <= ST_IDLE;
                            busy_q    <= 1'b0;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    bit_cnt_q <= 3'd0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_framed_encoder_tx.sv
// -----------------------------------------------------------------------------
// tb_framed_encoder_tx
//
// Testbench for framed_encoder_tx. The reference model is a queue of pending
// line bits. An accepted byte appends its bits, preceded by the preamble if
// the line was idle. The queue front is the bit sent in the current cycle,
// and zeros are sent when the queue is empty. The encoded stream is rebuilt
// from the recurrence over the model's own output history. A far-end decoder
// runs on the observed `out` and must recover each sent bit.
// -----------------------------------------------------------------------------
module tb_framed_encoder_tx;

    localparam int unsigned PRE_LEN = 8;
    localparam logic [7:0]  PRE_PAT = 8'hA5;

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic [7:0] data_in    = 8'd0;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       out;
    logic       busy;

    always #5 clk = ~clk;

    framed_encoder_tx #(
        .PRE_LEN     (PRE_LEN),
        .PRE_PATTERN (PRE_PAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .out        (out),
        .busy       (busy)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit q[$];       // line bits still to be sent; q[0] is the current bit
    bit yh[6];      // model encoder output history, yh[0] = y[n-1]
    bit dh[6];      // far-end decoder history of observed out
    logic last_out;
    logic last_dec;
    logic last_ready;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 6; i++) begin
            yh[i] = 1'b0;
            dh[i] = 1'b0;
        end
    endtask

    // One clock: drive inputs after the falling edge, check ready, then check
    // out/busy and the decoded bit just after the rising edge.
    task automatic step(input logic v, input logic [7:0] d);
        bit x, y, xfer, was_empty, dec;
        logic [7:0] pat;
        @(negedge clk);
        data_valid = v;
        data_in    = d;
        #1;
        last_ready = data_ready;
        check_eq("ready", 32'(data_ready), 32'(q.size() <= 1));
        x         = (q.size() != 0) ? q[0] : 1'b0;
        xfer      = v && (q.size() <= 1);
        was_empty = (q.size() == 0);
        @(posedge clk);
        #1;
        y = x ^ yh[0] ^ yh[1] ^ yh[2] ^ yh[5];
        for (int i = 5; i > 0; i--) yh[i] = yh[i-1];
        yh[0] = y;
        if (!was_empty) void'(q.pop_front());
        if (xfer) begin
            pat = PRE_PAT;
            if (was_empty)
                for (int i = 0; i < int'(PRE_LEN); i++) q.push_back(pat[i]);
            for (int i = 0; i < 8; i++) q.push_back(d[i]);
        end
        check_eq("out", 32'(out), 32'(y));
        check_eq("busy", 32'(busy), 32'(q.size() != 0));
        dec = out ^ dh[0] ^ dh[1] ^ dh[2] ^ dh[5];
        for (int i = 5; i > 0; i--) dh[i] = dh[i-1];
        dh[0] = out;
        check_eq("decode", 32'(dec), 32'(x));
        last_out = out;
        last_dec = dec;
        $display("cyc v=%0b d=%02h rdy=%0b out=%0b busy=%0b dec=%0b x=%0b",
                 v, d, last_ready, out, busy, dec, x);
    endtask

    initial begin
        logic [15:0] bits;
        int          nready;

        // Reset and idle.
        model_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out", 32'(out), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'(data_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 8'h5A);
            check_eq("idle_out", 32'(last_out), 32'd0);
        end

        // Preamble encoding: first four encoded bits of A5 are all ones.
        step(1'b1, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00);
            check_eq("pre_out", 32'(last_out), 32'd1);
        end
        for (int i = 0; i < 13; i++) step(1'b0, 8'h00);
        check_eq("pre_end_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00);

        // Decoder loopback of 3C: preamble A5 then data 3C, LSB first.
        step(1'b1, 8'h3C);
        bits = 16'd0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00);
            bits[i] = last_dec;
        end
        check_eq("loop_bits", 32'(bits), 32'h3CA5);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00);
            check_eq("loop_zero", 32'(last_dec), 32'd0);
        end

        // Back-to-back: FF then 81 with valid held high.
        step(1'b1, 8'hFF);
        nready = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'h81);
            if (last_ready) nready++;
        end
        check_eq("b2b_ready_cnt", 32'(nready), 32'd1);
        bits = 16'd0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00);
            bits[i] = last_dec;
        end
        check_eq("b2b_second", 32'(bits[7:0]), 32'h81);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00);

        // Gap between bytes: return to idle, then a full preamble again.
        step(1'b1, 8'h96);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00);
        check_eq("gap_idle_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00);
        step(1'b1, 8'h4B);
        bits = 16'd0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00);
            bits[i] = last_dec;
        end
        check_eq("gap_frame", 32'(bits), 32'h4BA5);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00);

        // Reset mid-burst at data bit 3.
        step(1'b1, 8'hC3);
        for (int i = 0; i < int'(PRE_LEN) + 3; i++) step(1'b0, 8'h00);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("mid_rst_out", 32'(out), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_ready", 32'(data_ready), 32'd1);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 8'h69);
        bits = 16'd0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00);
            bits[i] = last_dec;
        end
        check_eq("post_rst_frame", 32'(bits), 32'h69A5);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, 8'($urandom));
        end
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
